// File: rtl/fifo_multichan_lane.sv
// One channel of the multi-channel FIFO: storage ring, pointers, occupancy,
// flush and optional same-cycle fall-through of a push into an empty queue.
module fifo_multichan_lane #(
   parameter int  Depth       = 8,
   parameter type T           = logic,
   parameter bit  FallThrough = 1'b0,
   localparam int CntW        = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            push_i,
   input  T                data_i,
   output logic            ready_o,
   output logic            valid_o,
   output T                data_o,
   input  logic            pop_i,
   output logic [CntW-1:0] usage_o
);

   localparam int PtrW = $clog2(Depth);

   typedef logic [PtrW-1:0] ptr_t;

   localparam ptr_t            PtrLast = ptr_t'(Depth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   T                mem_reg [Depth];
   ptr_t            wr_ptr_reg, wr_ptr_next;
   ptr_t            rd_ptr_reg, rd_ptr_next;
   logic [CntW-1:0] count_reg, count_next;

   logic empty;
   logic push_fire;
   logic pop_fire;
   logic ft_active;
   logic bypass;
   logic do_write;
   logic do_read;

   // Explicit wrap so any depth works, not only powers of two.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PtrLast) ? '0 : p + ptr_t'(1);
   endfunction

   assign empty     = (count_reg == '0);
   assign ready_o   = (count_reg != CntFull) && !flush_i;
   assign push_fire = push_i && ready_o;

   // Fall-through: the incoming word is presented directly while the queue is empty.
   assign ft_active = FallThrough && empty && push_fire && !rst_i;
   assign valid_o   = !flush_i && (!empty || ft_active);
   assign data_o    = ft_active ? data_i : mem_reg[rd_ptr_reg];
   assign pop_fire  = valid_o && pop_i;

   // A fall-through word consumed in the same cycle never touches storage.
   assign bypass    = ft_active && pop_fire;
   assign do_write  = push_fire && !bypass;
   assign do_read   = pop_fire && !bypass;

   assign usage_o   = count_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_write) wr_ptr_next = ptr_inc(wr_ptr_reg);
         if (do_read)  rd_ptr_next = ptr_inc(rd_ptr_reg);
         count_next = count_reg + CntW'(do_write) - CntW'(do_read);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < Depth; i++) mem_reg[i] <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (do_write) mem_reg[wr_ptr_reg] <= data_i;
      end
   end

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      push_fire |-> (count_reg != CntFull));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      do_read |-> !empty);
`endif

endmodule

// File: rtl/fifo_multichan.sv
// Single-clock multi-channel FIFO: one steered push port, one pop port per
// channel, per-channel flush, fill level and almost-full flag.
module fifo_multichan #(
   parameter int  NumChan          = 4,
   parameter int  Depth            = 8,
   parameter type T                = logic,
   parameter bit  FallThrough      = 1'b0,
   parameter int  AlmostFullThresh = Depth - 1,
   localparam int ChanW            = (NumChan > 1) ? $clog2(NumChan) : 1,
   localparam int CntW             = $clog2(Depth + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumChan-1:0] flush_i,
   input  logic [ChanW-1:0]   push_chan_i,
   input  T                   push_data_i,
   input  logic               push_valid_i,
   output logic               push_ready_o,
   output T                   pop_data_o    [NumChan],
   output logic [NumChan-1:0] pop_valid_o,
   input  logic [NumChan-1:0] pop_ready_i,
   output logic [CntW-1:0]    usage_o       [NumChan],
   output logic [NumChan-1:0] almost_full_o
);

   localparam logic [ChanW:0]  NumChanW = (ChanW + 1)'(NumChan);
   localparam logic [CntW-1:0] AfThresh = CntW'(AlmostFullThresh);

   logic [NumChan-1:0] lane_push;
   logic [NumChan-1:0] lane_ready;
   logic               chan_ok;

   // Channel indices past NumChan are refused rather than aliased.
   assign chan_ok = ({1'b0, push_chan_i} < NumChanW);

   for (genvar gi = 0; gi < NumChan; gi++) begin : g_lane
      assign lane_push[gi] = push_valid_i && chan_ok && (push_chan_i == ChanW'(gi));

      fifo_multichan_lane #(
         .Depth       (Depth),
         .T           (T),
         .FallThrough (FallThrough)
      ) u_lane (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i[gi]),
         .push_i  (lane_push[gi]),
         .data_i  (push_data_i),
         .ready_o (lane_ready[gi]),
         .valid_o (pop_valid_o[gi]),
         .data_o  (pop_data_o[gi]),
         .pop_i   (pop_ready_i[gi]),
         .usage_o (usage_o[gi])
      );

      assign almost_full_o[gi] = (usage_o[gi] >= AfThresh);
   end

   always_comb begin
      push_ready_o = 1'b0;
      for (int c = 0; c < NumChan; c++) begin
         if (chan_ok && (push_chan_i == ChanW'(c))) push_ready_o = lane_ready[c];
      end
   end

`ifndef SYNTHESIS
   a_params: assert property (@(posedge clk_i)
      (Depth >= 2) && (AlmostFullThresh >= 1) && (AlmostFullThresh <= Depth));
   a_chan_range: assert property (@(posedge clk_i) disable iff (rst_i)
      push_valid_i |-> chan_ok);
`endif

endmodule

// File: tb/tb_fifo_multichan.sv
// Self-checking bench for fifo_multichan: tables, hand sequences and a
// per-channel scoreboard driving random traffic.
module tb_fifo_multichan;

   localparam int NC = 4;
   localparam int DP = 5;
   localparam int TH = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: registered output, threshold 3
   logic [NC-1:0] a_flush;
   logic [1:0]    a_chan;
   logic [7:0]    a_data;
   logic          a_pv;
   logic          a_ready;
   logic [7:0]    a_pop_data [NC];
   logic [NC-1:0] a_pop_valid;
   logic [NC-1:0] a_pop_ready;
   logic [2:0]    a_usage [NC];
   logic [NC-1:0] a_af;

   // Instance B: fall-through
   logic [NC-1:0] b_flush;
   logic [1:0]    b_chan;
   logic [7:0]    b_data;
   logic          b_pv;
   logic          b_ready;
   logic [7:0]    b_pop_data [NC];
   logic [NC-1:0] b_pop_valid;
   logic [NC-1:0] b_pop_ready;
   logic [2:0]    b_usage [NC];
   logic [NC-1:0] b_af;

   fifo_multichan #(
      .NumChan(NC), .Depth(DP), .T(logic [7:0]), .FallThrough(1'b0), .AlmostFullThresh(TH)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .push_chan_i(a_chan),
      .push_data_i(a_data), .push_valid_i(a_pv), .push_ready_o(a_ready),
      .pop_data_o(a_pop_data), .pop_valid_o(a_pop_valid), .pop_ready_i(a_pop_ready),
      .usage_o(a_usage), .almost_full_o(a_af)
   );

   fifo_multichan #(
      .NumChan(NC), .Depth(DP), .T(logic [7:0]), .FallThrough(1'b1)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .push_chan_i(b_chan),
      .push_data_i(b_data), .push_valid_i(b_pv), .push_ready_o(b_ready),
      .pop_data_o(b_pop_data), .pop_valid_o(b_pop_valid), .pop_ready_i(b_pop_ready),
      .usage_o(b_usage), .almost_full_o(b_af)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mq [NC][$];

   typedef struct {
      logic [1:0] ch;
      logic [7:0] d;
      logic       pv;
      logic       exp_ready;
      logic [2:0] exp_usage;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle on instance A, check against the scoreboard, then
   // retire the handshakes that occur at the next edge.
   task automatic step_a(input logic [3:0] fl, input logic [1:0] ch, input logic [7:0] d,
                         input logic pv, input logic [3:0] pr);
      logic       exp_rdy;
      logic [3:0] ev;
      @(posedge clk);
      #1;
      a_flush = fl; a_chan = ch; a_data = d; a_pv = pv; a_pop_ready = pr;
      @(negedge clk);
      exp_rdy = (mq[ch].size() < DP) && !fl[ch];
      check("push_ready", 32'(a_ready), 32'(exp_rdy));
      for (int c = 0; c < NC; c++) begin
         ev[c] = !fl[c] && (mq[c].size() != 0);
         check($sformatf("pop_valid[%0d]", c), 32'(a_pop_valid[c]), 32'(ev[c]));
         if (ev[c]) check($sformatf("pop_data[%0d]", c), 32'(a_pop_data[c]), 32'(mq[c][0]));
         check($sformatf("usage[%0d]", c), 32'(a_usage[c]), mq[c].size());
         check($sformatf("almost_full[%0d]", c), 32'(a_af[c]), 32'(mq[c].size() >= TH));
      end
      for (int c = 0; c < NC; c++) begin
         if (fl[c]) mq[c].delete();
         else if (ev[c] && pr[c]) void'(mq[c].pop_front());
      end
      if (pv && exp_rdy) mq[ch].push_back(d);
   endtask

   task automatic idle_a();
      step_a(4'h0, 2'd0, 8'h00, 1'b0, 4'h0);
   endtask

   vec_t fill_tab [6];

   initial begin
      rst = 1'b1;
      a_flush = '0; a_chan = '0; a_data = '0; a_pv = 1'b0; a_pop_ready = '0;
      b_flush = '0; b_chan = '0; b_data = '0; b_pv = 1'b0; b_pop_ready = '0;

      fill_tab[0] = '{2'd2, 8'h11, 1'b1, 1'b1, 3'd0};
      fill_tab[1] = '{2'd2, 8'h12, 1'b1, 1'b1, 3'd1};
      fill_tab[2] = '{2'd2, 8'h13, 1'b1, 1'b1, 3'd2};
      fill_tab[3] = '{2'd2, 8'h14, 1'b1, 1'b1, 3'd3};
      fill_tab[4] = '{2'd2, 8'h15, 1'b1, 1'b1, 3'd4};
      fill_tab[5] = '{2'd2, 8'h16, 1'b1, 1'b0, 3'd5};

      // Power-up reset
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(a_ready), 32'd1);
      check("rst_valid", 32'(a_pop_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Reset in the middle of traffic
      step_a(4'h0, 2'd0, 8'h01, 1'b1, 4'h0);
      step_a(4'h0, 2'd1, 8'h02, 1'b1, 4'h0);
      step_a(4'h0, 2'd0, 8'h03, 1'b1, 4'h1);
      @(posedge clk);
      #1;
      rst = 1'b1; a_pv = 1'b1; a_chan = 2'd0; a_data = 8'h77; a_pop_ready = 4'hF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_valid", 32'(a_pop_valid), 32'd0);
         check("midrst_ready", 32'(a_ready), 32'd1);
         for (int c = 0; c < NC; c++) check($sformatf("midrst_usage[%0d]", c), 32'(a_usage[c]), 32'd0);
         if (k < 2) @(posedge clk);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; a_pv = 1'b0; a_pop_ready = '0;
      for (int c = 0; c < NC; c++) mq[c].delete();
      @(negedge clk);
      check("postrst_valid", 32'(a_pop_valid), 32'd0);
      check("postrst_ready", 32'(a_ready), 32'd1);

      // Fill channel 2 to its depth, then one refused push
      for (int i = 0; i < 6; i++) begin
         step_a(4'h0, fill_tab[i].ch, fill_tab[i].d, fill_tab[i].pv, 4'h0);
         check($sformatf("fill%0d_ready", i), 32'(a_ready), 32'(fill_tab[i].exp_ready));
         check($sformatf("fill%0d_usage", i), 32'(a_usage[2]), 32'(fill_tab[i].exp_usage));
         $display("vec %0d: ch=%0d data=%02h ready=%0b usage2=%0d", i, fill_tab[i].ch,
                  fill_tab[i].d, a_ready, a_usage[2]);
      end

      // Alternate pop/push across the pointer wrap
      for (int i = 0; i < 12; i++) begin
         step_a(4'h0, 2'd2, 8'h00, 1'b0, 4'b0100);
         check("wrap_pop_data", 32'(a_pop_data[2]), 32'(8'h11 + i));
         check("wrap_pop_usage", 32'(a_usage[2]), 32'd5);
         step_a(4'h0, 2'd2, 8'(8'h16 + i), 1'b1, 4'h0);
         check("wrap_push_usage", 32'(a_usage[2]), 32'd4);
      end

      // Full channel: push refused even while being popped
      step_a(4'h0, 2'd2, 8'h40, 1'b1, 4'b0100);
      check("full_pop_ready", 32'(a_ready), 32'd0);
      check("full_pop_data", 32'(a_pop_data[2]), 32'h1D);
      step_a(4'h0, 2'd2, 8'h41, 1'b1, 4'h0);
      check("full_after_usage", 32'(a_usage[2]), 32'd4);
      check("full_after_ready", 32'(a_ready), 32'd1);
      idle_a();
      check("full_refill_usage", 32'(a_usage[2]), 32'd5);

      // Flush one channel while another keeps its contents
      step_a(4'hF, 2'd0, 8'h00, 1'b0, 4'h0);
      step_a(4'h0, 2'd1, 8'h31, 1'b1, 4'h0);
      step_a(4'h0, 2'd1, 8'h32, 1'b1, 4'h0);
      step_a(4'h0, 2'd3, 8'h51, 1'b1, 4'h0);
      step_a(4'h0, 2'd1, 8'h33, 1'b1, 4'h0);
      step_a(4'h0, 2'd3, 8'h52, 1'b1, 4'h0);
      step_a(4'b0010, 2'd1, 8'h34, 1'b1, 4'h0);
      check("flush_ready", 32'(a_ready), 32'd0);
      check("flush_valid1", 32'(a_pop_valid[1]), 32'd0);
      idle_a();
      check("flush_usage1", 32'(a_usage[1]), 32'd0);
      check("flush_usage3", 32'(a_usage[3]), 32'd2);
      check("flush_data3", 32'(a_pop_data[3]), 32'h51);
      check("flush_valid3", 32'(a_pop_valid[3]), 32'd1);

      // Almost-full threshold crossing on channel 0
      step_a(4'h0, 2'd0, 8'h61, 1'b1, 4'h0);
      step_a(4'h0, 2'd0, 8'h62, 1'b1, 4'h0);
      step_a(4'h0, 2'd0, 8'h63, 1'b1, 4'h0);
      check("af_before", 32'(a_af[0]), 32'd0);
      idle_a();
      check("af_rise", 32'(a_af[0]), 32'd1);
      step_a(4'h0, 2'd0, 8'h00, 1'b0, 4'b0001);
      check("af_pop_cycle", 32'(a_af[0]), 32'd1);
      idle_a();
      check("af_fall", 32'(a_af[0]), 32'd0);

      // Random traffic against the scoreboard
      for (int n = 0; n < 10000; n++) begin
         logic [3:0] fl;
         for (int c = 0; c < NC; c++) fl[c] = ($urandom_range(63) == 0);
         step_a(fl, 2'($urandom_range(3)), 8'($urandom), 1'($urandom_range(9) < 7),
                4'($urandom));
      end

      // Fall-through instance: same-cycle bypass, then a stored entry
      @(posedge clk);
      #1;
      b_chan = 2'd0; b_data = 8'hA5; b_pv = 1'b1; b_pop_ready = 4'b0001;
      @(negedge clk);
      check("ft_valid", 32'(b_pop_valid[0]), 32'd1);
      check("ft_data", 32'(b_pop_data[0]), 32'hA5);
      check("ft_ready", 32'(b_ready), 32'd1);
      @(posedge clk);
      #1;
      b_pv = 1'b0; b_pop_ready = '0;
      @(negedge clk);
      check("ft_bypass_usage", 32'(b_usage[0]), 32'd0);
      check("ft_bypass_valid", 32'(b_pop_valid[0]), 32'd0);
      @(posedge clk);
      #1;
      b_data = 8'h5A; b_pv = 1'b1;
      @(negedge clk);
      check("ft2_valid", 32'(b_pop_valid[0]), 32'd1);
      check("ft2_data", 32'(b_pop_data[0]), 32'h5A);
      @(posedge clk);
      #1;
      b_pv = 1'b0;
      @(negedge clk);
      check("ft2_usage", 32'(b_usage[0]), 32'd1);
      check("ft2_held_data", 32'(b_pop_data[0]), 32'h5A);
      @(posedge clk);
      #1;
      b_pop_ready = 4'b0001;
      @(posedge clk);
      #1;
      b_pop_ready = '0;
      @(negedge clk);
      check("ft2_drained", 32'(b_usage[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
